// File: rtl/beat_loop_controller_if.sv
// beat_loop_controller_if: pulse inputs and registered position outputs of the beat loop controller
interface beat_loop_controller_if;
  logic beat_tick;
  logic play_pulse;
  logic stop_pulse;
  logic loop_pulse;
  logic width_up;
  logic width_down;
  logic [11:0] ibeat;
  logic [11:0] bound;
  logic [11:0] loop_start;
  logic [2:0] loop_width;
  logic looping;
  logic playing;
  logic song_end;
  modport master (
    output beat_tick, play_pulse, stop_pulse, loop_pulse, width_up, width_down,
    input ibeat, bound, loop_start, loop_width, looping, playing, song_end
  );
  modport slave (
    input beat_tick, play_pulse, stop_pulse, loop_pulse, width_up, width_down,
    output ibeat, bound, loop_start, loop_width, looping, playing, song_end
  );
endinterface

// File: rtl/beat_loop_controller.sv
// beat_loop_controller: beat position sequencer with play/pause/stop and UNIT-aligned loop region; ports clk, rst_n (async low), bus (slave: pulses in, ibeat/bound/loop_start/loop_width/looping/playing/song_end out, all registered)
module beat_loop_controller #(
  parameter int LEN = 96,
  parameter int UNIT = 8
) (
  input logic clk,
  input logic rst_n,
  beat_loop_controller_if.slave bus
);
  typedef enum logic [1:0] {STOP, PLAY, PAUSE} state_t;
  localparam logic [11:0] LEN_W = 12'(LEN);
  localparam logic [11:0] UNIT_W = 12'(UNIT);
  state_t state, state_n;
  logic [11:0] ibeat_n, bound_n, start_n, inc;
  logic [2:0] width_n;
  logic looping_n, song_end_n, adv;
  function automatic logic [11:0] region_end(input logic [11:0] s, input logic [2:0] w);
    logic [11:0] e;
    e = s + ({9'd0, w} + 12'd1) * UNIT_W;
    return e < LEN_W ? e : LEN_W;
  endfunction
  always_comb begin
    state_n = state;
    ibeat_n = bus.ibeat;
    bound_n = bus.bound;
    start_n = bus.loop_start;
    width_n = bus.loop_width;
    looping_n = bus.looping;
    song_end_n = 1'b0;
    inc = bus.ibeat + 12'd1;
    adv = state == PLAY && bus.beat_tick && !bus.play_pulse && !bus.stop_pulse;
    if (bus.stop_pulse) begin
      state_n = STOP;
      ibeat_n = '0;
    end else if (bus.play_pulse) begin
      state_n = state == PLAY ? PAUSE : PLAY;
    end else if (adv) begin
      if (inc < bus.bound) ibeat_n = inc;
      else if (bus.looping) ibeat_n = bus.loop_start;
      else begin
        ibeat_n = '0;
        state_n = STOP;
        song_end_n = 1'b1;
      end
    end
    // loop_start comes from the pre-advance ibeat; width changes reach bound one cycle late
    // because the recompute below always uses the registered loop_width
    if (bus.loop_pulse) begin
      looping_n = !bus.looping;
      start_n = bus.looping ? '0 : bus.ibeat - bus.ibeat % UNIT_W;
      bound_n = bus.looping ? LEN_W : region_end(start_n, bus.loop_width);
    end else if (bus.looping) begin
      bound_n = region_end(bus.loop_start, bus.loop_width);
    end
    // a shrinking region or a late loop enable must not leave ibeat past the end
    if (ibeat_n >= bound_n) ibeat_n = start_n;
    if (bus.width_up && !bus.width_down && bus.loop_width != 3'd7) width_n = bus.loop_width + 3'd1;
    else if (bus.width_down && !bus.width_up && bus.loop_width != 3'd0) width_n = bus.loop_width - 3'd1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STOP;
      bus.ibeat <= '0;
      bus.bound <= LEN_W;
      bus.loop_start <= '0;
      bus.loop_width <= '0;
      bus.looping <= 1'b0;
      bus.playing <= 1'b0;
      bus.song_end <= 1'b0;
    end else begin
      state <= state_n;
      bus.ibeat <= ibeat_n;
      bus.bound <= bound_n;
      bus.loop_start <= start_n;
      bus.loop_width <= width_n;
      bus.looping <= looping_n;
      bus.playing <= state_n == PLAY;
      bus.song_end <= song_end_n;
    end
  end
endmodule

// File: tb/tb_beat_loop_controller.sv
// tb_beat_loop_controller: directed vectors with a cycle-tagged expectation queue checked by a separate monitor
module tb_beat_loop_controller;
  typedef struct packed {
    logic [11:0] ib;
    logic [11:0] bd;
    logic [11:0] ls;
    logic [2:0] w;
    logic lp;
    logic pl;
    logic se;
  } snap_t;
  typedef struct {
    int cyc;
    snap_t s;
    string nm;
  } exp_t;
  localparam logic [5:0] T = 6'b100000, P = 6'b010000, S = 6'b001000,
                         L = 6'b000100, U = 6'b000010, D = 6'b000001, N = 6'b000000;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  snap_t got;
  beat_loop_controller_if bus();
  beat_loop_controller #(.LEN(96), .UNIT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign got = {bus.ibeat, bus.bound, bus.loop_start, bus.loop_width, bus.looping, bus.playing, bus.song_end};
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      checks++;
      if (q[0].cyc < cyc) begin
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled (now %0d)", q[0].nm, q[0].cyc, cyc);
      end else if (got !== q[0].s) begin
        errors++;
        $display("FAIL %s: got ib=%0d bd=%0d ls=%0d w=%0d lp=%b pl=%b se=%b, need ib=%0d bd=%0d ls=%0d w=%0d lp=%b pl=%b se=%b",
          q[0].nm, got.ib, got.bd, got.ls, got.w, got.lp, got.pl, got.se,
          q[0].s.ib, q[0].s.bd, q[0].s.ls, q[0].s.w, q[0].s.lp, q[0].s.pl, q[0].s.se);
      end
      void'(q.pop_front());
    end
  end
  function automatic snap_t mk(int ib, int bd, int ls, int w, bit lp, bit pl, bit se);
    return {12'(ib), 12'(bd), 12'(ls), 3'(w), lp, pl, se};
  endfunction
  task automatic step(input logic [5:0] in, input snap_t e, input string nm);
    @(negedge clk);
    {bus.beat_tick, bus.play_pulse, bus.stop_pulse, bus.loop_pulse, bus.width_up, bus.width_down} = in;
    q.push_back('{cyc + 1, e, nm});
    @(posedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d, need finish", cyc);
    $fatal(1, "watchdog");
  end
  initial begin
    step(N, mk(0, 96, 0, 0, 0, 0, 0), "reset");
    @(negedge clk) rst_n = 1'b1;
    step(P, mk(0, 96, 0, 0, 0, 1, 0), "play");
    for (int i = 1; i <= 95; i++) step(T, mk(i, 96, 0, 0, 0, 1, 0), i <= 5 ? "tick_start" : "tick_run");
    step(T, mk(0, 96, 0, 0, 0, 0, 1), "song_end");
    step(N, mk(0, 96, 0, 0, 0, 0, 0), "song_end_clear");
    step(T, mk(0, 96, 0, 0, 0, 0, 0), "stop_no_adv");
    step(U, mk(0, 96, 0, 1, 0, 0, 0), "w_up1");
    step(P, mk(0, 96, 0, 1, 0, 1, 0), "play2");
    for (int i = 1; i <= 13; i++) step(T, mk(i, 96, 0, 1, 0, 1, 0), "tick_to13");
    step(L, mk(13, 24, 8, 1, 1, 1, 0), "loop_en13");
    for (int i = 14; i <= 23; i++) step(T, mk(i, 24, 8, 1, 1, 1, 0), "tick_loop");
    step(T, mk(8, 24, 8, 1, 1, 1, 0), "loop_wrap8");
    step(L, mk(8, 96, 0, 1, 0, 1, 0), "loop_dis");
    step(U, mk(8, 96, 0, 2, 0, 1, 0), "w_up2");
    for (int i = 9; i <= 89; i++) step(T, mk(i, 96, 0, 2, 0, 1, 0), "tick_to89");
    step(L, mk(89, 96, 88, 2, 1, 1, 0), "loop_en88_clip");
    for (int i = 90; i <= 95; i++) step(T, mk(i, 96, 88, 2, 1, 1, 0), "tick_tail");
    step(T, mk(88, 96, 88, 2, 1, 1, 0), "wrap88");
    step(S, mk(0, 96, 88, 2, 1, 0, 0), "stop_keep_loop");
    step(L, mk(0, 96, 0, 2, 0, 0, 0), "loop_dis2");
    step(U, mk(0, 96, 0, 3, 0, 0, 0), "w_up3");
    step(P, mk(0, 96, 0, 3, 0, 1, 0), "play3");
    for (int i = 1; i <= 12; i++) step(T, mk(i, 96, 0, 3, 0, 1, 0), "tick_to12");
    step(L, mk(12, 40, 8, 3, 1, 1, 0), "loop_en12");
    for (int i = 13; i <= 30; i++) step(T, mk(i, 40, 8, 3, 1, 1, 0), "tick_to30");
    step(P, mk(30, 40, 8, 3, 1, 0, 0), "pause");
    step(T, mk(30, 40, 8, 3, 1, 0, 0), "pause_no_adv");
    step(D, mk(30, 40, 8, 2, 1, 0, 0), "w_down_a");
    step(N, mk(30, 32, 8, 2, 1, 0, 0), "bound32");
    step(D, mk(30, 32, 8, 1, 1, 0, 0), "w_down_b");
    step(N, mk(8, 24, 8, 1, 1, 0, 0), "bound24_jump");
    step(L, mk(8, 96, 0, 1, 0, 0, 0), "loop_dis3");
    step(P, mk(8, 96, 0, 1, 0, 1, 0), "resume");
    for (int i = 9; i <= 40; i++) step(T, mk(i, 96, 0, 1, 0, 1, 0), "tick_to40");
    step(P | S | T, mk(0, 96, 0, 1, 0, 0, 0), "stop_wins");
    for (int k = 1; k <= 9; k++) step(U, mk(0, 96, 0, k + 1 > 7 ? 7 : k + 1, 0, 0, 0), "w_up_sat");
    step(U | D, mk(0, 96, 0, 7, 0, 0, 0), "w_up_down");
    for (int k = 1; k <= 8; k++) step(D, mk(0, 96, 0, 7 - k < 0 ? 0 : 7 - k, 0, 0, 0), "w_down_sat");
    step(P, mk(0, 96, 0, 0, 0, 1, 0), "play4");
    step(L, mk(0, 8, 0, 0, 1, 1, 0), "loop_en0");
    for (int i = 1; i <= 7; i++) step(T, mk(i, 8, 0, 0, 1, 1, 0), "tick_short");
    step(T, mk(0, 8, 0, 0, 1, 1, 0), "wrap0");
    step(T, mk(1, 8, 0, 0, 1, 1, 0), "tick_after_wrap");
    @(negedge clk);
    {bus.beat_tick, bus.play_pulse, bus.stop_pulse, bus.loop_pulse, bus.width_up, bus.width_down} = T;
    #2 rst_n = 1'b0;
    q.push_back('{cyc + 1, mk(0, 96, 0, 0, 0, 0, 0), "reset_mid_loop"});
    @(posedge clk);
    step(N, mk(0, 96, 0, 0, 0, 0, 0), "reset_hold");
    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, need 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/beat_loop_controller.md
Name: beat_loop_controller

Overview:
- Playback position sequencer for the music player.
- Advances the current beat index on tempo ticks, handles play/pause/stop, and manages an A-B style loop region whose length is set in units of UNIT beats.
- Drives ibeat, bound and loop_width to the seven-segment display stage, and ibeat to the note ROM.
- Sits directly upstream of the display controller, downstream of the tempo divider and the debounced one-pulse button stages.

Parameters:
- LEN, 96: song length in beats; valid ibeat range is 0..LEN-1. Must be ≤ 99 so each value fits two display digits.
- UNIT, 8: loop granularity in beats. Loop start is aligned to a multiple of UNIT.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- beat_tick  input  1  one-cycle pulse per beat from the tempo divider
- play_pulse  input  1  one-cycle pulse. From STOP or PAUSE it starts playback; from PLAY it pauses.
- stop_pulse  input  1  one-cycle pulse: stop and rewind
- loop_pulse  input  1  one-cycle pulse: toggle loop on/off
- width_up  input  1  one-cycle pulse: loop_width+1, saturating at 7
- width_down  input  1  one-cycle pulse: loop_width-1, saturating at 0
- ibeat  output  12  current beat index, registered
- bound  output  12  exclusive end of the active region, registered
- loop_start  output  12  start of the active region, registered
- loop_width  output  3  loop length code; loop length = (loop_width+1)*UNIT
- looping  output  1  loop active
- playing  output  1  high in PLAY
- song_end  output  1  one-cycle pulse when a non-looped song finishes

Behaviour:
- Reset (async, rst_n=0):
  - state=STOP, ibeat=0, loop_start=0, bound=LEN, loop_width=0, looping=0, playing=0, song_end=0.
- State transitions (evaluated each clk):
  - stop_pulse from any state → STOP, ibeat=0; looping is kept.
  - play_pulse: STOP→PLAY, PAUSE→PLAY, PLAY→PAUSE.
  - If stop_pulse and play_pulse arrive in the same cycle, stop wins.
- Advance:
  - Only in PLAY, on beat_tick.
  - A beat_tick in the same cycle as any state transition is ignored: no advance.
  - If ibeat+1 < bound: ibeat ← ibeat+1.
  - Else, if looping: ibeat ← loop_start.
  - Else: ibeat ← 0, state → STOP, song_end=1 for one cycle.
- Loop enable (loop_pulse while looping=0):
  - looping ← 1.
  - loop_start ← ibeat rounded down to a multiple of UNIT.
  - bound ← min(loop_start + (loop_width+1)*UNIT, LEN).
- Loop disable (loop_pulse while looping=1):
  - looping ← 0, loop_start ← 0, bound ← LEN; ibeat unchanged.
- Width change:
  - Saturates at 0 and 7. width_up and width_down in the same cycle → no change.
  - When looping=1, bound is recomputed from the new width in the cycle after loop_width updates.
  - If ibeat ≥ the new bound, ibeat ← loop_start in the same cycle bound updates.
  - When looping=0, only loop_width changes.
- Pulse coincidence:
  - loop_pulse coincident with a beat_tick advance: the advance is applied first, and loop_start is computed from the pre-advance ibeat.
  - loop_pulse coincident with width_up/width_down: the loop uses the old width; the new width applies via the recompute rule on the following cycle.
- Arithmetic:
  - All index math is 12-bit unsigned; the min() compare is unsigned.
  - ibeat < bound ≤ LEN always holds one cycle after any event.
- Outputs: all registered, no combinational paths from inputs to outputs. playing = (state==PLAY).
- Latency: every input pulse is reflected on the outputs one cycle after the pulse cycle.
- Reset during PLAY or mid-loop: immediate return to the reset values above; no song_end pulse.

Test Plan:
- Reset, then play_pulse, then 5 beat_ticks → ibeat=5, playing=1, bound=96, looping=0.
- Play through to ibeat=95, then beat_tick → ibeat=0, STOP, song_end high exactly 1 cycle, playing=0.
- At ibeat=13, loop_width=1, loop_pulse → loop_start=8, bound=24. Ticks from 23 → ibeat=8.
- Looping with loop_start=88, width 2 → bound=min(112,96)=96, and the wrap at 95 goes to 88.
- Looping with loop_start=8, width=3, ibeat=30: width_down twice → bound 32 then 24; ibeat jumps to 8 when bound=24.
- At ibeat=40 in PLAY: play_pulse+stop_pulse+beat_tick in the same cycle → STOP, ibeat=0. Then width_up 9 times → loop_width=7. width_up+width_down together → still 7.
